// File: rtl/knn_pkg.sv
// Shared definitions for the KNN batch scheduler: state codes, default timing
// parameters and the batch-count width.
package knn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int SORT_LATENCY_DEF = 2;
    localparam int RD_TIMEOUT_DEF   = 16;
    localparam int NB_W             = 6;
    localparam int MAX_BATCHES      = 32;

    // A request is only legal for 1..MAX_BATCHES batches.
    function automatic logic count_legal(input logic [NB_W-1:0] n);
        return (n != 6'd0) && (n <= NB_W'(MAX_BATCHES));
    endfunction

endpackage

// File: rtl/knn_batch_scheduler.sv
// Sequences a KNN classification: clears the sorter, streams training batches
// from memory into it, waits out the sorter latency and publishes the group.
module knn_batch_scheduler
    import knn_pkg::*;
#(
    parameter int SORT_LATENCY = SORT_LATENCY_DEF,
    parameter int RD_TIMEOUT   = RD_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    output logic            o_ready,
    input  logic [9:0]      i_test_x,
    input  logic [9:0]      i_test_y,
    input  logic [NB_W-1:0] i_num_batches,
    input  logic            i_abort,
    output logic [9:0]      o_test_x,
    output logic [9:0]      o_test_y,
    output logic            o_mem_rd_en,
    output logic [4:0]      o_mem_addr,
    input  logic            i_mem_rd_valid,
    output logic            o_clr_sort,
    output logic            o_sort_en,
    input  logic            i_group,
    output logic            o_group,
    output logic            o_result_valid,
    output logic            o_err,
    output logic            o_busy,
    output logic [2:0]      o_state
);

    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
    localparam int DRN_W = $clog2(SORT_LATENCY + 1);

    state_t            state_r;
    logic [9:0]        test_x_r;
    logic [9:0]        test_y_r;
    logic [NB_W-1:0]   num_r;
    logic [4:0]        batch_cnt_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic [DRN_W-1:0]  drain_cnt_r;
    logic              group_r;
    logic              mem_rd_en_r;
    logic              clr_sort_r;
    logic              result_valid_r;
    logic              err_r;
    logic              last_batch_s;

    assign last_batch_s   = ({1'b0, batch_cnt_r} == (num_r - 6'd1));
    assign o_ready        = (state_r == ST_IDLE);
    assign o_busy         = (state_r != ST_IDLE);
    assign o_state        = state_r;
    assign o_sort_en      = (state_r == ST_WAIT) && i_mem_rd_valid;
    assign o_test_x       = test_x_r;
    assign o_test_y       = test_y_r;
    assign o_mem_addr     = batch_cnt_r;
    assign o_mem_rd_en    = mem_rd_en_r;
    assign o_clr_sort     = clr_sort_r;
    assign o_group        = group_r;
    assign o_result_valid = result_valid_r;
    assign o_err          = err_r;

    // Scheduler FSM; strobes are registered on entry to the state that owns them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            test_x_r       <= 10'd0;
            test_y_r       <= 10'd0;
            num_r          <= 6'd0;
            batch_cnt_r    <= 5'd0;
            tmo_cnt_r      <= '0;
            drain_cnt_r    <= '0;
            group_r        <= 1'b0;
            mem_rd_en_r    <= 1'b0;
            clr_sort_r     <= 1'b0;
            result_valid_r <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            mem_rd_en_r    <= 1'b0;
            clr_sort_r     <= 1'b0;
            result_valid_r <= 1'b0;
            err_r          <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_req) begin
                        if (count_legal(i_num_batches)) begin
                            test_x_r   <= i_test_x;
                            test_y_r   <= i_test_y;
                            num_r      <= i_num_batches;
                            clr_sort_r <= 1'b1;
                            state_r    <= ST_CLEAR;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (i_abort) begin
                        state_r <= ST_IDLE;
                    end else begin
                        batch_cnt_r <= 5'd0;
                        mem_rd_en_r <= 1'b1;
                        state_r     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (i_abort) begin
                        state_r <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= '0;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Abort wins over a returning read; the sorter strobe is combinational.
                    if (i_abort) begin
                        state_r <= ST_IDLE;
                    end else if (i_mem_rd_valid) begin
                        if (last_batch_s) begin
                            drain_cnt_r <= '0;
                            state_r     <= ST_DRAIN;
                        end else begin
                            batch_cnt_r <= batch_cnt_r + 5'd1;
                            mem_rd_en_r <= 1'b1;
                            state_r     <= ST_FETCH;
                        end
                    end else if (tmo_cnt_r == TMO_W'(RD_TIMEOUT - 1)) begin
                        err_r   <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (i_abort) begin
                        state_r <= ST_IDLE;
                    end else if (drain_cnt_r == DRN_W'(SORT_LATENCY - 1)) begin
                        group_r        <= i_group;
                        result_valid_r <= 1'b1;
                        state_r        <= ST_DONE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DRN_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
